// File: rtl/serializer_frame_ctrl.sv
// Byte scheduler in front of the 8-bit serializer: packs 12-bit I/Q pairs into
// 4-byte frames (sync, I hi, I lo/Q hi, Q lo) and inserts fill bytes when idle.
module serializer_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sample_valid,
  input  logic [11:0] sample_i,
  input  logic [11:0] sample_q,
  output logic        sample_ready,
  input  logic        dr,
  output logic [7:0]  data,
  output logic        oe,
  output logic [15:0] frames_sent
);

  localparam logic [2:0] StOff   = 3'd0;
  localparam logic [2:0] StFill  = 3'd1;
  localparam logic [2:0] StSync  = 3'd2;
  localparam logic [2:0] StIHi   = 3'd3;
  localparam logic [2:0] StIqMid = 3'd4;
  localparam logic [2:0] StQLo   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic        oe_q, oe_d;
  logic [11:0] buf_i_q, buf_i_d, buf_q_q, buf_q_d;
  logic        buf_full_q, buf_full_d;
  logic [11:0] fr_i_q, fr_i_d, fr_q_q, fr_q_d;
  logic [15:0] frames_q, frames_d;
  logic        accept, enter_sync, frame_done;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StOff: begin
        if (en) state_d = StFill;
      end
      StFill: begin
        if (dr) begin
          if (!en)            state_d = StOff;
          else if (buf_full_q) state_d = StSync;
        end
      end
      StSync:  if (dr) state_d = StIHi;
      StIHi:   if (dr) state_d = StIqMid;
      StIqMid: if (dr) state_d = StQLo;
      StQLo: begin
        // en is only honoured once the frame is complete
        if (dr) begin
          if (!en)             state_d = StOff;
          else if (buf_full_q) state_d = StSync;
          else                 state_d = StFill;
        end
      end
      default: state_d = StOff;
    endcase
  end

  assign accept     = sample_valid && !buf_full_q;
  assign enter_sync = (state_d == StSync) && (state_q != StSync);
  assign frame_done = (state_q == StQLo) && dr;

  always_comb begin
    buf_i_d    = accept ? sample_i : buf_i_q;
    buf_q_d    = accept ? sample_q : buf_q_q;
    // enter_sync requires a full buffer, so it can never coincide with accept
    buf_full_d = enter_sync ? 1'b0 : (accept ? 1'b1 : buf_full_q);
    fr_i_d     = enter_sync ? buf_i_q : fr_i_q;
    fr_q_d     = enter_sync ? buf_q_q : fr_q_q;
    frames_d   = frame_done ? frames_q + 16'd1 : frames_q;
    oe_d       = (state_d != StOff);
  end

  always_comb begin
    data_d = FILL_BYTE;
    case (state_d)
      StSync:  data_d = SYNC_BYTE;
      StIHi:   data_d = fr_i_d[11:4];
      StIqMid: data_d = {fr_i_d[3:0], fr_q_d[11:8]};
      StQLo:   data_d = fr_q_d[7:0];
      default: data_d = FILL_BYTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StOff;
      data_q     <= FILL_BYTE;
      oe_q       <= 1'b0;
      buf_i_q    <= '0;
      buf_q_q    <= '0;
      buf_full_q <= 1'b0;
      fr_i_q     <= '0;
      fr_q_q     <= '0;
      frames_q   <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      oe_q       <= oe_d;
      buf_i_q    <= buf_i_d;
      buf_q_q    <= buf_q_d;
      buf_full_q <= buf_full_d;
      fr_i_q     <= fr_i_d;
      fr_q_q     <= fr_q_d;
      frames_q   <= frames_d;
    end
  end

  assign sample_ready = !buf_full_q;
  assign data         = data_q;
  assign oe           = oe_q;
  assign frames_sent  = frames_q;

endmodule
